// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses pll_rst, qualifies lock as stable, then releases sys_rst_n.
// Build option PLL_LOCK_AUTORESET_EN: lock loss in RUN re-resets the PLL instead of waiting for relock.
module pll_lock_sequencer #(
  parameter int HOLD_CYCLES   = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 8
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             locked,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             pll_ready,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [CNT_W-1:0] retry_cnt,
  output logic [1:0]       state
);

  localparam int MAX_HT  = (HOLD_CYCLES > LOCK_TIMEOUT) ? HOLD_CYCLES : LOCK_TIMEOUT;
  localparam int TMR_MAX = (MAX_HT > STABLE_CYCLES) ? MAX_HT : STABLE_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] HOLD_LAST    = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

`ifdef PLL_LOCK_AUTORESET_EN
  localparam state_t LOSS_NEXT = RESET_PLL;
`else
  localparam state_t LOSS_NEXT = WAIT_LOCK;
`endif

  state_t           cur;
  state_t           nxt;
  logic [TMR_W-1:0] timer;
  logic             sync1;
  logic             lk;
  logic             retry_inc;
  logic             loss_inc;

  // locked is asynchronous to refclk; only lk may be used by the FSM
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      lk    <= 1'b0;
    end else begin
      sync1 <= locked;
      lk    <= sync1;
    end
  end

  always_comb begin
    nxt       = cur;
    retry_inc = 1'b0;
    loss_inc  = 1'b0;
    case (cur)
      RESET_PLL: if (timer == HOLD_LAST) nxt = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lk) begin
          nxt = STABLE;
        end else if (timer == TIMEOUT_LAST) begin
          nxt       = RESET_PLL;
          retry_inc = 1'b1;
        end
      end
      STABLE: begin
        if (!lk) nxt = WAIT_LOCK;
        else if (timer == STABLE_LAST) nxt = RUN;
      end
      RUN: begin
        if (!lk) begin
          nxt      = LOSS_NEXT;
          loss_inc = 1'b1;
        end
      end
      default: nxt = RESET_PLL;
    endcase
  end

  // Outputs are registered from nxt so they change on the same edge as the state
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cur           <= RESET_PLL;
      timer         <= '0;
      pll_rst       <= 1'b1;
      sys_rst_n     <= 1'b0;
      pll_ready     <= 1'b0;
      lock_loss_cnt <= '0;
      retry_cnt     <= '0;
    end else begin
      cur       <= nxt;
      pll_rst   <= (nxt == RESET_PLL);
      sys_rst_n <= (nxt == RUN);
      pll_ready <= (nxt == RUN);
      if (nxt != cur) timer <= '0;
      else if (cur != RUN) timer <= timer + 1'b1;
      if (retry_inc && (retry_cnt != {CNT_W{1'b1}})) retry_cnt <= retry_cnt + 1'b1;
      if (loss_inc && (lock_loss_cnt != {CNT_W{1'b1}})) lock_loss_cnt <= lock_loss_cnt + 1'b1;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed scenarios plus a randomized lock pattern against a phase model.
module tb_pll_lock_sequencer;
  localparam int HOLD = 4, TO = 100, ST = 8, CW = 2, CMAX = (1 << CW) - 1;

  logic          refclk = 1'b0;
  logic          rst_n  = 1'b0;
  logic          locked = 1'b0;
  logic          pll_rst, sys_rst_n, pll_ready;
  logic [CW-1:0] lock_loss_cnt, retry_cnt;
  logic [1:0]    state;

  pll_lock_sequencer #(
    .HOLD_CYCLES(HOLD), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(ST), .CNT_W(CW)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .locked(locked), .pll_rst(pll_rst),
    .sys_rst_n(sys_rst_n), .pll_ready(pll_ready), .lock_loss_cnt(lock_loss_cnt),
    .retry_cnt(retry_cnt), .state(state)
  );

  always #10 refclk = ~refclk;

  int n_checks = 0;
  int n_pass   = 0;

  int pll_hi_cnt = 0;
  int sys_hi_cnt = 0;
  always @(negedge refclk) begin
    if (pll_rst === 1'b1) pll_hi_cnt++;
    if (sys_rst_n === 1'b1) sys_hi_cnt++;
  end

  // Phase model: 0 hold PLL in reset, 1 wait for lock, 2 qualify lock, 3 running
  int m_phase, m_elapsed, m_loss, m_retry;
  bit m_seen0, m_seen1;
`ifdef PLL_LOCK_AUTORESET_EN
  localparam int LOSS_GOTO = 0;
`else
  localparam int LOSS_GOTO = 1;
`endif

  task automatic model_reset();
    m_phase = 0; m_elapsed = 0; m_loss = 0; m_retry = 0; m_seen0 = 0; m_seen1 = 0;
  endtask

  task automatic model_edge(input bit lin);
    bit lkv;
    int goto_phase;
    lkv = m_seen1;
    goto_phase = m_phase;
    if (m_phase == 0 && m_elapsed + 1 == HOLD) goto_phase = 1;
    else if (m_phase == 1 && lkv) goto_phase = 2;
    else if (m_phase == 1 && m_elapsed + 1 == TO) begin
      goto_phase = 0;
      m_retry = (m_retry < CMAX) ? m_retry + 1 : CMAX;
    end else if (m_phase == 2 && !lkv) goto_phase = 1;
    else if (m_phase == 2 && m_elapsed + 1 == ST) goto_phase = 3;
    else if (m_phase == 3 && !lkv) begin
      goto_phase = LOSS_GOTO;
      m_loss = (m_loss < CMAX) ? m_loss + 1 : CMAX;
    end
    m_elapsed = (goto_phase != m_phase) ? 0 : m_elapsed + 1;
    m_phase = goto_phase;
    m_seen1 = m_seen0;
    m_seen0 = lin;
  endtask

  wire [8:0] dut_vec = {state, pll_rst, sys_rst_n, pll_ready, lock_loss_cnt, retry_cnt};
  localparam logic [8:0] RESET_VEC = {2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0};

  function automatic logic [8:0] exp_vec();
    return {2'(m_phase), (m_phase == 0), (m_phase == 3), (m_phase == 3), CW'(m_loss), CW'(m_retry)};
  endfunction

  task automatic cyc();
    @(posedge refclk);
    if (rst_n) model_edge(locked);
    #1;
  endtask

  task automatic wait_state(input int st, input int bound, output int edges);
    edges = -1;
    for (int i = 1; i <= bound; i++) begin
      cyc();
      if (state === 2'(st)) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    locked = 1'b0;
    model_reset();
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; locked = 1'b0;
    model_reset();
    cyc(); cyc(); cyc();
    n_checks++; if (dut_vec !== RESET_VEC) $display("FAIL reset_vec: got %h want %h", dut_vec, RESET_VEC); else n_pass++;
    rst_n = 1'b1;
    n_checks++; if (pll_rst !== 1'b1) $display("FAIL reset_release_pll_rst: got %b want 1", pll_rst); else n_pass++;
  endtask

  // Expects rst_n just released with locked low
  task automatic powerup_seq();
    int e;
    wait_state(1, 50, e);
    n_checks++; if (e !== HOLD) $display("FAIL powerup_hold: got %0d want %0d", e, HOLD); else n_pass++;
    n_checks++; if (dut_vec !== exp_vec()) $display("FAIL powerup_wait: dut %h model %h", dut_vec, exp_vec()); else n_pass++;
    repeat (10) cyc();
    locked = 1'b1;
    cyc();
    wait_state(2, 20, e);
    n_checks++; if (e !== 2) $display("FAIL powerup_stable_entry: got %0d want 2", e); else n_pass++;
    wait_state(3, 50, e);
    n_checks++; if (e !== ST) $display("FAIL powerup_stable_len: got %0d want %0d", e, ST); else n_pass++;
    n_checks++;
    if ({sys_rst_n, pll_ready, lock_loss_cnt, retry_cnt} !== {1'b1, 1'b1, 2'd0, 2'd0})
      $display("FAIL powerup_run: got sys=%b rdy=%b loss=%0d retry=%0d want 1 1 0 0", sys_rst_n, pll_ready, lock_loss_cnt, retry_cnt);
    else n_pass++;
  endtask

  task automatic test_powerup();
    powerup_seq();
  endtask

  task automatic test_timeout();
    int e, sys0;
    do_reset();
    wait_state(1, 50, e);
    sys0 = sys_hi_cnt;
    for (int k = 1; k <= 4; k++) begin
      wait_state(0, TO + 20, e);
      n_checks++; if (e !== TO) $display("FAIL timeout_len[%0d]: got %0d want %0d", k, e, TO); else n_pass++;
      n_checks++; if (retry_cnt !== CW'((k < CMAX) ? k : CMAX)) $display("FAIL timeout_retry[%0d]: got %0d want %0d", k, retry_cnt, (k < CMAX) ? k : CMAX); else n_pass++;
      wait_state(1, 20, e);
      n_checks++; if (e !== HOLD) $display("FAIL timeout_pulse[%0d]: got %0d want %0d", k, e, HOLD); else n_pass++;
    end
    n_checks++; if (sys_hi_cnt !== sys0) $display("FAIL timeout_sys_rst: got %0d high cycles want 0", sys_hi_cnt - sys0); else n_pass++;
  endtask

  task automatic test_glitch();
    int e, pll0;
    do_reset();
    wait_state(1, 50, e);
    locked = 1'b1;
    cyc();
    wait_state(2, 20, e);
    repeat (5) cyc();
    pll0 = pll_hi_cnt;
    locked = 1'b0;
    repeat (3) cyc();
    n_checks++; if (state !== 2'd1) $display("FAIL glitch_back_to_wait: got %0d want 1", state); else n_pass++;
    locked = 1'b1;
    cyc();
    wait_state(2, 20, e);
    n_checks++; if (e !== 2) $display("FAIL glitch_relock: got %0d want 2", e); else n_pass++;
    wait_state(3, 50, e);
    n_checks++; if (e !== ST) $display("FAIL glitch_full_stable: got %0d want %0d", e, ST); else n_pass++;
    n_checks++; if (pll_hi_cnt !== pll0) $display("FAIL glitch_pll_rst: got %0d high cycles want 0", pll_hi_cnt - pll0); else n_pass++;
    n_checks++; if (retry_cnt !== 2'd0) $display("FAIL glitch_retry: got %0d want 0", retry_cnt); else n_pass++;
  endtask

  task automatic test_loss_run();
    int e, pll0;
    locked = 1'b0;
    cyc(); cyc(); cyc();
    n_checks++; if ({sys_rst_n, pll_ready} !== 2'b00) $display("FAIL loss_outputs: got sys=%b rdy=%b want 0 0", sys_rst_n, pll_ready); else n_pass++;
    n_checks++; if (lock_loss_cnt !== 2'd1) $display("FAIL loss_count: got %0d want 1", lock_loss_cnt); else n_pass++;
    pll0 = pll_hi_cnt;
`ifdef PLL_LOCK_AUTORESET_EN
    wait_state(1, 20, e);
    n_checks++; if (pll_hi_cnt - pll0 !== HOLD) $display("FAIL loss_repulse: got %0d want %0d", pll_hi_cnt - pll0, HOLD); else n_pass++;
`else
    repeat (10) cyc();
    n_checks++; if (pll_hi_cnt !== pll0 || state !== 2'd1) $display("FAIL loss_no_repulse: got %0d high cycles state %0d want 0 and 1", pll_hi_cnt - pll0, state); else n_pass++;
`endif
    locked = 1'b1;
    wait_state(3, 100, e);
    n_checks++; if (dut_vec !== exp_vec()) $display("FAIL loss_rerun: dut %h model %h", dut_vec, exp_vec()); else n_pass++;
  endtask

  task automatic test_saturation();
    int e, want;
    do_reset();
    wait_state(1, 50, e);
    locked = 1'b1;
    wait_state(3, 100, e);
    for (int i = 1; i <= 5; i++) begin
      locked = 1'b0;
      repeat (3) cyc();
      want = (i < CMAX) ? i : CMAX;
      n_checks++; if (lock_loss_cnt !== CW'(want)) $display("FAIL sat_loss[%0d]: got %0d want %0d", i, lock_loss_cnt, want); else n_pass++;
      locked = 1'b1;
      wait_state(3, 300, e);
      n_checks++; if (e === -1) $display("FAIL sat_rerun[%0d]: got timeout want RUN", i); else n_pass++;
    end
    repeat (20) cyc();
    n_checks++; if (lock_loss_cnt !== 2'd3) $display("FAIL sat_hold: got %0d want 3", lock_loss_cnt); else n_pass++;
  endtask

  task automatic test_async_reset();
    int e;
    locked = 1'b0;
    repeat (4) cyc();
    locked = 1'b1;
    wait_state(2, 300, e);
    repeat ($urandom_range(1, 6)) cyc();
    #4 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (dut_vec !== RESET_VEC) $display("FAIL async_reset_vec: got %h want %h", dut_vec, RESET_VEC); else n_pass++;
    locked = 1'b0;
    cyc();
    rst_n = 1'b1;
    powerup_seq();
  endtask

  task automatic test_random();
    int run_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run_left == 0) begin
        locked = ($urandom_range(0, 3) != 0);
        run_left = locked ? $urandom_range(1, 400) : $urandom_range(1, 150);
      end
      run_left--;
      cyc();
      n_checks++; if (dut_vec !== exp_vec()) $display("FAIL random[%0d]: dut %h model %h", i, dut_vec, exp_vec()); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_timeout();
    test_glitch();
    test_loss_run();
    test_saturation();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
